// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU operation encodings and HI/LO read-back select constants.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    localparam logic MF_LO = 1'b0;
    localparam logic MF_HI = 1'b1;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 2W-bit multiply and truncating divide for the MDU.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_p,
    output logic [WIDTH-1:0] lo_p,
    output logic             div0
);

    logic signed [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0]        uprod;
    logic [2*WIDTH-1:0]        prod;
    logic                      is_mul;
    logic                      sgn;
    logic [WIDTH-1:0]          ua;
    logic [WIDTH-1:0]          ub;
    logic [WIDTH-1:0]          dv;
    logic [WIDTH-1:0]          uq;
    logic [WIDTH-1:0]          ur;
    logic [WIDTH-1:0]          q;
    logic [WIDTH-1:0]          r;

    assign sprod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uprod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod   = (op == MDU_MULT) ? sprod : uprod;
    assign is_mul = (op == MDU_MULT) || (op == MDU_MULTU);

    // Signed divide runs on magnitudes; the most negative dividend over -1
    // wraps back to itself naturally, so no overflow special case is needed.
    assign sgn  = (op == MDU_DIV);
    assign div0 = (b == '0);
    assign ua   = (sgn && a[WIDTH-1]) ? -a : a;
    assign ub   = (sgn && b[WIDTH-1]) ? -b : b;
    assign dv   = div0 ? WIDTH'(1) : ub;
    assign uq   = ua / dv;
    assign ur   = ua % dv;
    assign q    = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
    assign r    = (sgn && a[WIDTH-1]) ? -ur : ur;

    assign hi_p = is_mul ? prod[2*WIDTH-1:WIDTH] : r;
    assign lo_p = is_mul ? prod[WIDTH-1:0] : q;

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MfSel,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] RD
);

    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_p;
    logic [WIDTH-1:0] lo_p;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic             div0;
    logic             commit_p;
    logic             accept;
    logic             is_div;
    logic             is_md;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op   (MDUOp),
        .a    (A),
        .b    (B),
        .hi_p (hi_n),
        .lo_p (lo_n),
        .div0 (div0)
    );

    assign Busy   = (cnt != '0);
    assign accept = Start && !Busy;
    assign is_div = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
    assign is_md  = is_div || (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);
    assign RD     = (MfSel == MF_HI) ? HI : LO;

    // accept implies cnt==0, so commit and mthi/mtlo never collide.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            HI       <= '0;
            LO       <= '0;
            hi_p     <= '0;
            lo_p     <= '0;
            commit_p <= 1'b0;
        end else begin
            if (accept && is_md) begin
                cnt      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                hi_p     <= hi_n;
                lo_p     <= lo_n;
                commit_p <= !(is_div && div0);
            end else if (Busy) begin
                cnt <= cnt - CW'(1);
            end
            if (cnt == CW'(1) && commit_p) begin
                HI <= hi_p;
                LO <= lo_p;
            end else if (accept && MDUOp == MDU_MTHI) begin
                HI <= A;
            end else if (accept && MDUOp == MDU_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench; issued mult/div ops queue expected HI/LO and Busy length.
module tb_mdu_unit;
    import mdu_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        Clk = 0;
    logic        Reset = 1;
    logic        Start = 0;
    logic [2:0]  MDUOp = MDU_NOP;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        MfSel = MF_LO;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] RD;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    logic prev_busy = 0;

    mdu_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .MfSel (MfSel),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO),
        .RD    (RD)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1;
        MDUOp = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 0;
        MDUOp = MDU_NOP;
    endtask

    task automatic op_exp(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                          input int cyc);
        q.push_back('{nm, hi, lo, cyc});
        issue(op, a, b);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (Busy && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        checks++;
        if (Busy) begin
            errors++;
            $display("FAIL %s_timeout: Busy still %b after %0d cycles", nm, Busy, n);
        end
    endtask

    // Monitor: a falling Busy marks a completion; compare against the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            prev_busy = 0;
            run       = 0;
        end else begin
            if (Busy) run++;
            else if (prev_busy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got HI %h LO %h expected no op", HI, LO);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_hi"}, HI, e.hi);
                    chk({e.name, "_lo"}, LO, e.lo);
                    chk({e.name, "_busy_cycles"}, 32'(run), 32'(e.cyc));
                end
                run = 0;
            end
            prev_busy = Busy;
        end
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        Reset = 0;
        @(posedge Clk);
        #1;
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_busy", 32'(Busy), 0);
        MfSel = MF_HI;
        #1;
        chk("rst_rd_hi", RD, 0);
        MfSel = MF_LO;
        #1;
        chk("rst_rd_lo", RD, 0);

        op_exp("mult", MDU_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        chk("mult_busy_rise", 32'(Busy), 1);
        chk("mult_hi_held", HI, 0);
        wait_idle("mult");
        MfSel = MF_HI;
        #1;
        chk("mult_rd_hi", RD, 32'hFFFFFFFF);
        MfSel = MF_LO;

        op_exp("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, 5);
        wait_idle("multu");
        op_exp("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_idle("div");
        op_exp("divu0", MDU_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        chk("divu0_busy_rise", 32'(Busy), 1);
        wait_idle("divu0");

        op_exp("multu_3x4", MDU_MULTU, 32'd3, 32'd4, 32'h0, 32'd12, 5);
        issue(MDU_MTLO, 32'h1234, 32'h0);
        chk("mtlo_busy_ignored", LO, 32'hFFFFFFFD);
        wait_idle("multu_3x4");
        issue(MDU_MTLO, 32'h1234, 32'h0);
        chk("mtlo_lo", LO, 32'h1234);
        chk("mtlo_busy", 32'(Busy), 0);
        issue(MDU_MTHI, 32'hABCD, 32'h0);
        chk("mthi_hi", HI, 32'hABCD);
        chk("mthi_busy", 32'(Busy), 0);
        issue(MDU_NOP, 32'h5555, 32'h0);
        chk("nop_hi", HI, 32'hABCD);
        chk("nop_lo", LO, 32'h1234);

        op_exp("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10);
        wait_idle("div_ovf");
        op_exp("div_negb", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 10);
        wait_idle("div_negb");
        op_exp("divu", MDU_DIVU, 32'hFFFFFFFF, 32'd16, 32'hF, 32'h0FFFFFFF, 10);
        wait_idle("divu");

        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (2) @(posedge Clk);
        #3;
        Reset = 1;
        #1;
        chk("rstmid_busy", 32'(Busy), 0);
        chk("rstmid_hi", HI, 0);
        chk("rstmid_lo", LO, 0);
        @(negedge Clk);
        @(posedge Clk);
        #1;
        Reset = 0;
        op_exp("mult_2x3", MDU_MULT, 32'd2, 32'd3, 32'h0, 32'd6, 5);
        wait_idle("mult_2x3");
        chk("after_rst_rd", RD, 32'd6);
        @(negedge Clk);
        #1;
        chk("sb_drained", 32'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
